// File: rtl/pwm_pkg.sv
// Definitions shared by the PWM generator and the PWM capture block.
package pwm_pkg;
  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {IDLE, ARM, MEAS} cap_state_e;

  // A quotient of exactly 2**DUTY_W (100% duty) saturates to all-ones.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W:0] q);
    return q[DUTY_W] ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/pwm_div.sv
// Restoring divider: quo = floor(num * 2**DUTY_W / den), one quotient bit per cycle.
// Expects num <= den, so the first bit is the integer part and the quotient fits DUTY_W+1 bits.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [DUTY_W:0]  quo
);
  localparam int QW = DUTY_W + 1;
  localparam logic [3:0] LAST = 4'(QW - 1);

  logic [CNT_W:0]   rem_q;
  logic [CNT_W:0]   rem_d;
  logic [CNT_W-1:0] den_q;
  logic [QW-2:0]    quo_q;
  logic [QW-1:0]    quo_d;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             ge;
  logic [CNT_W-1:0] diff;

  always_comb begin
    ge    = rem_q >= {1'b0, den_q};
    diff  = ge ? CNT_W'(rem_q - {1'b0, den_q}) : rem_q[CNT_W-1:0];
    quo_d = {quo_q, ge};
    rem_d = {diff, 1'b0};
  end

  // The final bit is resolved combinationally so the result is usable in the last busy cycle.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign quo  = quo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= {1'b0, num};
      den_q  <= den;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d[QW-2:0];
      cnt_q <= cnt_q + 4'd1;
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of pwm_in between rising edges and reports a normalised
// duty once per period; a missing rising edge for TIMEOUT cycles reports stuck-low/high.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 2**CNT_W - 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              valid,
  output logic              stuck_lo,
  output logic              stuck_hi
);
  // Timeout fires on the cycle whose count would reach TIMEOUT, giving a TIMEOUT-cycle repeat.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d_q, rise;
  cap_state_e             state_q, state_d;
  logic [CNT_W-1:0]       per_q, per_d, high_q, high_d;
  logic [CNT_W-1:0]       win_per_q, win_high_q;
  logic                   tmo, div_start, div_busy, div_done;
  logic [DUTY_W:0]        div_quo;
  logic [DUTY_W-1:0]      duty_q;
  logic [CNT_W-1:0]       high_cnt_q, period_cnt_q;
  logic                   valid_q, stuck_lo_q, stuck_hi_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      per_q      <= '0;
      high_q     <= '0;
      win_per_q  <= '0;
      win_high_q <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      high_q  <= high_d;
      if (div_start) begin
        win_per_q  <= per_q;
        win_high_q <= high_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    high_d    = high_q;
    div_start = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        per_d  = '0;
        high_d = '0;
        state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          state_d = MEAS;
          per_d   = CNT_W'(1);
          high_d  = CNT_W'(1);
        end else if (per_q == TO_LAST) begin
          tmo    = 1'b1;
          per_d  = '0;
          high_d = '0;
        end else begin
          per_d = per_q + CNT_W'(1);
        end
      end
      MEAS: begin
        // The rise cycle opens the next window; a window closing mid-divide is dropped.
        if (rise) begin
          per_d     = CNT_W'(1);
          high_d    = CNT_W'(1);
          div_start = ~div_busy;
        end else if (per_q == TO_LAST) begin
          tmo     = 1'b1;
          state_d = ARM;
          per_d   = '0;
          high_d  = '0;
        end else begin
          per_d  = per_q + CNT_W'(1);
          high_d = high_q + CNT_W'(s);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d   = IDLE;
      per_d     = '0;
      high_d    = '0;
      div_start = 1'b0;
      tmo       = 1'b0;
    end
  end

  pwm_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .abort (~en),
    .start (div_start),
    .num   (high_q),
    .den   (per_q),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      stuck_lo_q   <= 1'b0;
      stuck_hi_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tmo) begin
        valid_q      <= 1'b1;
        duty_q       <= s ? {DUTY_W{1'b1}} : '0;
        high_cnt_q   <= '0;
        period_cnt_q <= '0;
        stuck_lo_q   <= ~s;
        stuck_hi_q   <= s;
      end else if (div_done && en) begin
        valid_q      <= 1'b1;
        duty_q       <= clamp_duty(div_quo);
        high_cnt_q   <= win_high_q;
        period_cnt_q <= win_per_q;
        stuck_lo_q   <= 1'b0;
        stuck_hi_q   <= 1'b0;
      end
    end
  end

  assign duty       = duty_q;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign valid      = valid_q;
  assign stuck_lo   = stuck_lo_q;
  assign stuck_hi   = stuck_hi_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: each phase's waveform is fed to a window/timeout model that queues expected results.
module tb_pwm_capture;
  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 1050;
  localparam int SYNC    = 3;

  typedef struct {
    int cyc;
    int duty;
    int hi;
    int per;
    bit slo;
    bit shi;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, pwm_in;
  logic [7:0]       duty;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             valid, stuck_lo, stuck_hi;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   p_last;
  bit   wv[$];
  exp_t expq[$];
  exp_t mon_e;
  exp_t last_e;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .stuck_lo   (stuck_lo),
    .stuck_hi   (stuck_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"}, 32'(duty), 0);
    chk({tag, "_high"}, 32'(high_cnt), 0);
    chk({tag, "_period"}, 32'(period_cnt), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_stuck_lo"}, 32'(stuck_lo), 0);
    chk({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid at cycle %0d duty %0d, want none", cyc, duty);
      end else begin
        mon_e = expq.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("duty", 32'(duty), mon_e.duty);
        chk("high_cnt", 32'(high_cnt), mon_e.hi);
        chk("period_cnt", 32'(period_cnt), mon_e.per);
        chk("stuck_lo", 32'(stuck_lo), 32'(mon_e.slo));
        chk("stuck_hi", 32'(stuck_hi), 32'(mon_e.shi));
        last_e = mon_e;
      end
    end
  end

  task automatic add_const(input bit v, input int n);
    for (int i = 0; i < n; i++) wv.push_back(v);
  endtask

  task automatic add_pwm(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < per; i++) wv.push_back(bit'(i < hi));
  endtask

  task automatic push_exp(input int c, input int cut, input int d, input int hi, input int per,
                          input bit slo, input bit shi);
    exp_t e;
    if (c <= cut) begin
      e.cyc = c; e.duty = d; e.hi = hi; e.per = per; e.slo = slo; e.shi = shi;
      expq.push_back(e);
    end
  endtask

  // Windows run rise to rise; a result lands 10 cycles after the closing rise unless a kept
  // result closed fewer than 10 cycles earlier. No rise for TIMEOUT cycles reports stuck.
  task automatic model(input int k, input int cut);
    int n, ref_i, open_i, last_acc, hi, per, q;
    bit cur, prv;
    n = wv.size();
    ref_i = 1 - SYNC;
    open_i = -1;
    last_acc = -1000;
    for (int i = 0; i <= n - 1 - SYNC; i++) begin
      cur = wv[i];
      prv = (i == 0) ? p_last : wv[i-1];
      if (cur && !prv) begin
        if (open_i >= 0 && i - last_acc >= 10) begin
          per = i - open_i;
          hi = 0;
          for (int j = open_i; j < i; j++) hi += int'(wv[j]);
          q = (hi * 256) / per;
          if (q > 255) q = 255;
          push_exp(k + SYNC + i + 10, cut, q, hi, per, 1'b0, 1'b0);
          last_acc = i;
        end
        open_i = i;
        ref_i = i;
      end else if (i - ref_i == TIMEOUT - 1) begin
        push_exp(k + SYNC + i + 1, cut, cur ? 255 : 0, 0, 0, !cur, cur);
        open_i = -1;
        ref_i = i + 1;
      end
    end
  endtask

  task automatic run_phase(input bit end_with_rst);
    int k, n;
    @(posedge clk); #1;
    k = cyc;
    n = wv.size();
    model(k, end_with_rst ? k + n - 1 : k + n);
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      pwm_in = wv[i];
      if (i < n - 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    en = 1'b0;
    if (end_with_rst) rst = 1'b1;
    p_last = wv[n-1];
  endtask

  task automatic add_tail(input int zeros);
    add_const(1'b1, 1);
    add_const(1'b0, zeros);
  endtask

  initial begin
    int per, hi;
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; p_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    wv.delete();
    add_const(1'b0, 5);
    add_pwm(256, 128, 4);
    add_pwm(256, 255, 3);
    add_pwm(256, 1, 3);
    add_pwm(1000, 250, 3);
    add_pwm(12, 5, 6);
    add_tail(20);
    run_phase(1'b0);
    repeat (20) @(posedge clk);

    wv.delete();
    add_pwm(100, 30, 3);
    add_const(1'b0, 2300);
    add_const(1'b1, 2300);
    add_pwm(200, 50, 3);
    add_tail(20);
    run_phase(1'b0);
    repeat (20) @(posedge clk);

    wv.delete();
    for (int r = 0; r < 4; r++) begin
      add_pwm(6, 3, 1);
      add_pwm(256, 100, 1);
    end
    add_tail(20);
    run_phase(1'b0);
    repeat (20) @(posedge clk);

    // Enable drops four cycles after a window closes, while its divide is in progress.
    wv.delete();
    add_pwm(64, 20, 3);
    add_const(1'b1, 1);
    add_const(1'b0, SYNC + 4);
    run_phase(1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("hold_duty", 32'(duty), last_e.duty);
    chk("hold_high", 32'(high_cnt), last_e.hi);
    chk("hold_period", 32'(period_cnt), last_e.per);

    wv.delete();
    add_pwm(80, 30, 3);
    add_tail(20);
    run_phase(1'b1);
    #1 check_zero("mid_rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    wv.delete();
    add_pwm(40, 10, 4);
    add_tail(20);
    run_phase(1'b0);
    repeat (20) @(posedge clk);

    for (int ph = 0; ph < 3; ph++) begin
      wv.delete();
      for (int r = 0; r < 12; r++) begin
        per = $urandom_range(4, 300);
        hi = $urandom_range(1, per - 1);
        add_pwm(per, hi, 1);
      end
      add_tail($urandom_range(3, 40));
      run_phase(1'b0);
      repeat (20) @(posedge clk);
    end

    repeat (30) @(posedge clk);
    #1 chk("pending_results", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
